// File: rtl/memory_drainer.sv
// memory_drainer: reads words 0..arr_size-1 over an AR/R read channel and
// streams them out on a valid/ready port with a last flag. A small read-data
// FIFO absorbs downstream backpressure; the number of reads in flight is capped
// at the FIFO depth so every returning word always has a slot.
module memory_drainer #(
  parameter int ADDR_WDTH  = 4,
  parameter int DATA_WDTH  = 32,
  parameter int RESP_WDTH  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_WDTH:0]   arr_size,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 ar_valid,
  input  logic                 ar_ready,
  output logic [ADDR_WDTH-1:0] ar_address,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [DATA_WDTH-1:0] r_data,
  input  logic [RESP_WDTH-1:0] r_resp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_WDTH-1:0] out_data,
  output logic                 out_last
);

  localparam int          PTR_W   = $clog2(FIFO_DEPTH);
  localparam int          CNT_W   = ADDR_WDTH + 1;
  localparam logic [31:0] DEPTH_U = FIFO_DEPTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     size_q, size_d;
  logic [CNT_W-1:0]     ar_cnt_q, ar_cnt_d;
  logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]     inflight_d;
  logic                 ar_valid_q, ar_valid_d;
  logic                 err_q, err_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       fifo_cnt_q, fifo_cnt_d;
  logic [DATA_WDTH-1:0] fifo_mem_q [FIFO_DEPTH];

  logic push, pop, last_word, fifo_full;

  // Handshakes and output decode; nothing here depends combinationally on an input
  // except the handshake strobes themselves.
  assign r_ready    = (state_q == S_RUN);
  assign push       = r_valid && r_ready;
  assign out_valid  = (state_q == S_RUN) && (fifo_cnt_q != '0);
  assign pop        = out_valid && out_ready;
  assign out_data   = fifo_mem_q[rd_ptr_q];
  assign last_word  = (out_cnt_q == size_q - CNT_W'(1));
  assign out_last   = out_valid && last_word;
  assign fifo_full  = (fifo_cnt_q == (PTR_W+1)'(FIFO_DEPTH));
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign ar_valid   = ar_valid_q;
  assign ar_address = ar_cnt_q[ADDR_WDTH-1:0];

  // Next-state: FSM, counters, FIFO pointers and the registered AR request.
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    ar_cnt_d   = ar_cnt_q;
    out_cnt_d  = out_cnt_q;
    err_d      = err_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop) fifo_cnt_d = fifo_cnt_q + (PTR_W+1)'(1);
    if (pop && !push) fifo_cnt_d = fifo_cnt_q - (PTR_W+1)'(1);

    if (ar_valid_q && ar_ready) ar_cnt_d = ar_cnt_q + CNT_W'(1);
    if (pop) out_cnt_d = out_cnt_q + CNT_W'(1);
    // An error response is flagged but the word is still forwarded.
    if (push && (r_resp != '0)) err_d = 1'b1;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          size_d    = arr_size;
          ar_cnt_d  = '0;
          out_cnt_d = '0;
          err_d     = 1'b0;
          state_d   = (arr_size == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (pop && last_word) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Credit: only request while the FIFO is guaranteed room for the reply.
    // A pending request can never be withdrawn because credit only grows
    // while ar_cnt is frozen waiting for ar_ready.
    inflight_d = ar_cnt_d - out_cnt_d;
    ar_valid_d = (state_d == S_RUN) && (ar_cnt_d < size_d) &&
                 (32'(inflight_d) < DEPTH_U);
  end

  // Control registers; reset aborts any drain and empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      size_q     <= '0;
      ar_cnt_q   <= '0;
      out_cnt_q  <= '0;
      ar_valid_q <= 1'b0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      ar_cnt_q   <= ar_cnt_d;
      out_cnt_q  <= out_cnt_d;
      ar_valid_q <= ar_valid_d;
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= r_data;
  end

  // Credit accounting should make a push into a full, non-draining FIFO impossible.
  assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_memory_drainer.sv
// Scoreboard bench for memory_drainer: a memory responder serves AR/R, the main
// process issues drains and queues the expected words, a monitor checks the stream.
module tb_memory_drainer;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int RW = 1;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   arr_size = '0;
  logic          busy, done, err;
  logic          ar_valid;
  logic          ar_ready = 1'b0;
  logic [AW-1:0] ar_address;
  logic          r_valid = 1'b0;
  logic          r_ready;
  logic [DW-1:0] r_data = '0;
  logic [RW-1:0] r_resp = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;

  always #5 clk = ~clk;

  memory_drainer #(
    .ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .arr_size(arr_size),
    .busy(busy), .done(done), .err(err),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_address(ar_address),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  logic [DW-1:0] mem [16] = '{
    32'h1000_0001, 32'h2000_0002, 32'h3000_0003, 32'h4000_0004,
    32'h5000_0005, 32'h6000_0006, 32'h7000_0007, 32'h8000_0008,
    32'h9000_0009, 32'hA000_000A, 32'hB000_000B, 32'hC000_000C,
    32'hD000_000D, 32'hE000_000E, 32'hF000_000F, 32'h0BAD_F00D
  };

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // stimulus knobs
  bit ar_rand  = 1'b0;
  bit r_rand   = 1'b0;
  int out_mode = 0;   // 0 always ready, 1 never ready, 2 random
  int err_idx  = -1;

  // responder state
  int            pend_q[$];
  int            exp_addr = 0;
  int            ar_hs = 0;
  int            r_hs = 0;
  logic          prev_ar_stall = 1'b0;
  logic [AW-1:0] prev_ar_addr = '0;

  // monitor state
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  exp_t          mon_e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Memory model: accepts reads, answers them in order from the table.
  always @(negedge clk) begin
    if (rst) begin
      pend_q.delete();
      ar_ready      = 1'b0;
      r_valid       = 1'b0;
      r_resp        = '0;
      prev_ar_stall = 1'b0;
    end else begin
      if (start) begin
        exp_addr = 0;
        ar_hs    = 0;
        r_hs     = 0;
      end
      if (prev_ar_stall)
        chk("ar_stable", {63'(ar_address), ar_valid}, {63'(prev_ar_addr), 1'b1});
      r_valid = 1'b0;
      r_resp  = '0;
      r_data  = 32'hDEAD_BEEF;
      if (pend_q.size() > 0 && (!r_rand || $urandom_range(0, 1) == 1)) begin
        r_valid = 1'b1;
        r_data  = mem[pend_q[0]];
        r_resp  = (pend_q[0] == err_idx) ? RW'(1) : RW'(0);
        if (r_ready) begin
          void'(pend_q.pop_front());
          r_hs++;
        end
      end
      ar_ready = !ar_rand || ($urandom_range(0, 2) != 0);
      if (ar_valid && ar_ready) begin
        chk("ar_addr", 64'(ar_address), 64'(exp_addr));
        exp_addr++;
        ar_hs++;
        pend_q.push_back(int'(ar_address));
      end
      prev_ar_stall = ar_valid && !ar_ready;
      prev_ar_addr  = ar_address;
    end
  end

  // Output monitor: pops the scoreboard on every out handshake.
  always @(negedge clk) begin
    if (rst) begin
      out_ready  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("out_stable", {31'b0, out_valid, out_data}, {31'b0, 1'b1, prev_data});
      case (out_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected actual=%0h required=none", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(mon_e.data));
          chk("out_last", 64'(out_last), 64'(mon_e.last));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int sz);
    exp_t t;
    arr_size = (AW+1)'(sz);
    start    = 1'b1;
    for (int i = 0; i < sz; i++) begin
      t.data = mem[i];
      t.last = (i == sz - 1);
      exp_q.push_back(t);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int max);
    int n = 0;
    while (!done && n < max) begin
      tick();
      n++;
    end
    chk({nm, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic check_idle_outs(input string nm);
    chk(nm, {56'b0, busy, done, err, ar_valid, r_ready, out_valid, out_last, 1'b0} |
            64'(ar_address), 64'd0);
  endtask

  initial begin
    int n;
    // reset state
    repeat (3) tick();
    check_idle_outs("reset_outs");
    rst = 1'b0;
    tick();

    // 1: size 5, everything ready
    do_start(5);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_done("t1", 100);
    chk("t1_ar_count", 64'(ar_hs), 64'd5);
    chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("t1_done_outs", {60'b0, busy, ar_valid, r_ready, out_valid}, 64'd0);
    chk("t1_err", 64'(err), 64'd0);

    // 2: size 0 finishes immediately without reads
    do_start(0);
    chk("t2_done_next", {62'b0, done, busy}, 64'b10);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t2_quiet", {61'b0, ar_valid, out_valid, done}, 64'b001);
    end
    chk("t2_ar_count", 64'(ar_hs), 64'd0);

    // 3: downstream blocked, credit limits reads to FIFO depth
    out_mode = 1;
    do_start(8);
    repeat (12) tick();
    chk("t3_ar_credit", 64'(ar_hs), 64'd4);
    chk("t3_ar_idle", {62'b0, ar_valid, out_valid}, 64'b01);
    out_mode = 0;
    wait_done("t3", 200);
    chk("t3_ar_count", 64'(ar_hs), 64'd8);
    chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // 4: full array under random stalls everywhere
    ar_rand  = 1'b1;
    r_rand   = 1'b1;
    out_mode = 2;
    do_start(16);
    wait_done("t4", 2000);
    chk("t4_ar_count", 64'(ar_hs), 64'd16);
    chk("t4_sb_empty", 64'(exp_q.size()), 64'd0);
    ar_rand  = 1'b0;
    r_rand   = 1'b0;
    out_mode = 0;

    // 5: error response on address 2, sticky then cleared by next start
    err_idx = 2;
    do_start(4);
    chk("t5_err_clear", 64'(err), 64'd0);
    wait_done("t5", 100);
    chk("t5_err_set", 64'(err), 64'd1);
    chk("t5_sb_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();
    chk("t5_err_sticky", {62'b0, err, done}, 64'b11);
    err_idx = -1;
    do_start(3);
    chk("t5_err_restart", {62'b0, err, busy}, 64'b01);
    wait_done("t5b", 100);
    chk("t5b_err", 64'(err), 64'd0);
    chk("t5b_sb_empty", 64'(exp_q.size()), 64'd0);

    // 6: reset with two words buffered, then a clean drain
    out_mode = 1;
    do_start(6);
    n = 0;
    while (r_hs < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("t6_buffered", 64'(r_hs), 64'd2);
    chk("t6_out_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    tick();
    check_idle_outs("t6_reset_outs");
    exp_q.delete();
    tick();
    rst      = 1'b0;
    out_mode = 0;
    tick();
    do_start(6);
    wait_done("t6", 100);
    chk("t6_ar_count", 64'(ar_hs), 64'd6);
    chk("t6_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
